cic_decimator: RTL and testbench
================================

# cic_decimator

Parametrised N-stage CIC decimation filter; the next generation of our fixed 4-stage / ÷12 CIC micro-tile. Signed multi-bit input with a sample-valid strobe, run-time decimation ratio and output scaling, saturating output. Everything runs in the single `clk` domain: decimation uses a clock-enable strobe, never a derived clock. Sits between a PDM/ΣΔ front end and the downstream sample consumer.

## Interface
- `STAGES`, 4: number of integrator and comb stages N, 1..8.
- `IN_W`, 2: input width, two's complement, ≥2.
- `R_MAX`, 16: largest supported decimation ratio, ≥2.
- `R_DEF`, 12: ratio in force after reset or clear.
- `OUT_W`, 16: output width, two's complement.
- `ACC_W`, derived: IN_W + STAGES·clog2(R_MAX). Not overridable.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `clr` in 1: synchronous clear of all filter state. Same effect as reset; wins over all other inputs.
- `in_valid` in 1: `in_data` accepted on this edge.
- `in_data` in IN_W: signed sample.
- `dec_ratio` in clog2(R_MAX+1): requested ratio R.
- `out_shift` in clog2(ACC_W): arithmetic right shift applied to the comb result.
- `out_valid` out 1: one-cycle strobe, `out_data` is new.
- `out_data` out OUT_W: signed decimated sample.
- `out_sat` out 1: high with `out_valid` when `out_data` was clipped.

## Operation
- Reset/clear values:
  - all integrators, comb delays and the phase counter: 0
  - `ratio_q` = R_DEF
  - `out_valid` = 0, `out_data` = 0, `out_sat` = 0
- Integrators, updated only when `in_valid` is high:
  - `acc1 += sext(in_data)`
  - `acc_k += acc_{k-1}`, using the pre-edge value, so the integrators form a pipeline of N−1 samples.
  - Modulo 2^ACC_W; wrap-around is intended and must not be saturated.
- Phase counter:
  - Counts accepted samples from 0 to `ratio_q`−1.
  - On the edge that accepts sample `ratio_q`−1 (the decimation edge), the counter returns to 0 and `dec_stb` is registered.
- Ratio update:
  - `ratio_q` loads the clamped `dec_ratio` only on a decimation edge.
  - Clamp: values below 2 become 2; values above R_MAX become R_MAX.
  - A ratio change therefore never splits a frame.
- Comb section:
  - Runs on the cycle after `dec_stb`, with differential delay M=1.
  - `c0` = `acc_N` (post-update value). For each stage, `c_k = c_{k-1} − d_k` and `d_k <= c_{k-1}`.
  - Combinational chain, ACC_W modular arithmetic.
- Output stage:
  - `y = c_N >>> out_shift` (arithmetic shift, truncating).
  - If `y` exceeds the OUT_W signed range, `out_data` = max or min and `out_sat` = 1; otherwise `out_data` = `y` and `out_sat` = 0.
  - `out_sat` is only meaningful while `out_valid` is high; it is 0 otherwise.
- DC gain is R^N·2^−`out_shift`.

## Timing
- Decimation edge E. At E+1 the comb section and output register update, and `out_valid` is high for the single cycle after E+1. Latency is 2 clocks.
- `in_valid` asserted on the cycle after E is accepted normally and counts as sample 0 of the next frame; there is no back-pressure.
- `in_valid` may be high every cycle. Minimum `out_valid` spacing is therefore 2 clocks.
- `out_data` holds its value between strobes.
- Reset or clear mid-frame:
  - Phase and all state are lost.
  - A `dec_stb` pending from the previous edge is discarded: no `out_valid` follows.
- `out_shift` is sampled at E+1. It may change at any time without glitching other state.

## Structure
- Package `cic_pkg` holds:
  - the ACC_W derivation function
  - the ratio-clamp function
  - the saturate-to-OUT_W function
- Sub-module `cic_stage`, parameterised by width and kind (integrator or comb), is instantiated 2·N times in generate loops.
- The phase counter, ratio latch and output register live in the top module.

## Test plan
- Impulse and step response. N=4, R=12, `out_shift`=0, `in_data`=+1 every cycle → 5th and all later outputs = 20736, `out_sat`=0. Outputs are spaced exactly 12 accepted samples apart.
- Negative input with scaling. `in_data`=−2 constant, `out_shift`=8 → steady `out_data` = −162.
- Saturation. OUT_W=8, `in_data`=+1, `out_shift`=0 → steady `out_data`=127 with `out_sat`=1 on every strobe. With `in_data`=−2 → −128 and `out_sat`=1.
- Ratio change and clamping:
  - `dec_ratio` changed 12→5 mid-frame: the current frame still completes after 12 samples, then outputs come every 5 samples, and steady value = 5^4 for `in_data`=+1.
  - `dec_ratio`=0 gives outputs every 2 samples.
  - `dec_ratio`=31 gives outputs every 16 samples.
- Gapped input and long runs. `in_valid` is a random ~40% duty.
  - Outputs match a bit-exact reference model.
  - A 10^6-sample run with `in_data`=+1 and `out_shift`=0 keeps `out_data` at 20736, confirming correct integrator wrap-around.
- Reset and clear mid-operation:
  - `rst_n` pulsed on the decimation edge → no `out_valid` on either of the next two cycles, and all outputs are 0.
  - `clr` held together with `in_valid` → state stays at 0.
  - After release, the response is identical to a power-up run.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC decimator: width derivation,
// decimation-ratio clamping and output saturation.
package cic_pkg;

  // Working width for the saturation helper; must cover any accumulator width.
  localparam int SAT_W = 64;

  typedef enum logic {
    STG_INTEG,
    STG_COMB
  } stage_kind_e;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] val;
  } sat_t;

  // Accumulator width that cannot lose information for R_MAX^N gain.
  function automatic int acc_width(int in_w, int stages, int r_max);
    return in_w + stages * $clog2(r_max);
  endfunction

  // Ratios below 2 or above r_max are forced into the supported range.
  function automatic int clamp_ratio(int req, int r_max);
    if (req < 2) return 2;
    if (req > r_max) return r_max;
    return req;
  endfunction

  // Clip a sign-extended value into the signed out_w range.
  function automatic sat_t saturate(logic signed [SAT_W-1:0] y, int out_w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_t                    r;
    max_v = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
    min_v = -max_v - SAT_W'(1);
    r.sat = 1'b1;
    if (y > max_v) begin
      r.val = max_v;
    end else if (y < min_v) begin
      r.val = min_v;
    end else begin
      r.val = y;
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_if.sv
// Sample/control bundle between the front end, the CIC decimator and the
// downstream consumer. Widths are derived from the filter parameters.
interface cic_if #(
  parameter int STAGES = 4,
  parameter int IN_W   = 2,
  parameter int R_MAX  = 16,
  parameter int OUT_W  = 16
);
  import cic_pkg::*;

  localparam int ACC_W = acc_width(IN_W, STAGES, R_MAX);
  localparam int DR_W  = $clog2(R_MAX + 1);
  localparam int SH_W  = $clog2(ACC_W);

  logic                    clr;
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic [DR_W-1:0]         dec_ratio;
  logic [SH_W-1:0]         out_shift;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  modport master (
    output clr, in_valid, in_data, dec_ratio, out_shift,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  clr, in_valid, in_data, dec_ratio, out_shift,
    output out_valid, out_data, out_sat
  );

endinterface

// File: rtl/cic_stage.sv
// One CIC stage. An integrator accumulates its input and presents the
// registered sum; a comb stores its previous input (M=1) and presents the
// combinational difference. Both wrap modulo 2^W.
module cic_stage
  import cic_pkg::*;
#(
  parameter int          W    = 18,
  parameter stage_kind_e KIND = STG_INTEG
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] y_o
);

  logic signed [W-1:0] state_q;
  logic signed [W-1:0] state_d;

  // Next state and output depend on whether this is an integrator or a comb.
  always_comb begin
    if (KIND == STG_INTEG) begin
      state_d = state_q + x_i;
      y_o     = state_q;
    end else begin
      state_d = x_i;
      y_o     = x_i - state_q;
    end
  end

  // Stage register, advanced only on its enable; clear behaves like reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (clr_i) begin
      state_q <= '0;
    end else if (en_i) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator with run-time ratio and output scaling.
// Integrators advance per accepted sample; the comb chain and output
// register advance on the cycle after each decimation edge (clock enable,
// single clock domain).
module cic_decimator
  import cic_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int IN_W   = 2,
  parameter int R_MAX  = 16,
  parameter int R_DEF  = 12,
  parameter int OUT_W  = 16
) (
  input logic  clk,
  input logic  rst_n,
  cic_if.slave bus
);

  localparam int ACC_W = acc_width(IN_W, STAGES, R_MAX);
  localparam int RC_W  = $clog2(R_MAX + 1);

  logic                    accept;
  logic                    dec_edge;
  logic [RC_W-1:0]         phase_q, phase_d;
  logic [RC_W-1:0]         ratio_q, ratio_d;
  logic                    dec_stb_q;
  logic                    out_valid_q;
  logic                    out_sat_q;
  logic signed [OUT_W-1:0] out_data_q;
  logic signed [ACC_W-1:0] integ_y [STAGES+1];
  logic signed [ACC_W-1:0] shifted;
  sat_t                    sat_r;
  logic                    unused_sat_bits;

  // Sign-extended input feeds the first integrator.
  assign integ_y[0] = ACC_W'(bus.in_data);

  for (genvar k = 1; k <= STAGES; k++) begin : g_integ
    cic_stage #(.W(ACC_W), .KIND(STG_INTEG)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (bus.clr),
      .en_i  (accept),
      .x_i   (integ_y[k-1]),
      .y_o   (integ_y[k])
    );
  end

  // Comb stages chained through per-block nets to keep the chain acyclic.
  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    logic signed [ACC_W-1:0] c_in;
    logic signed [ACC_W-1:0] c_out;
    if (k == 0) begin : g_first
      assign c_in = integ_y[STAGES];
    end else begin : g_next
      assign c_in = g_comb[k-1].c_out;
    end
    cic_stage #(.W(ACC_W), .KIND(STG_COMB)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (bus.clr),
      .en_i  (dec_stb_q),
      .x_i   (c_in),
      .y_o   (c_out)
    );
  end

  // Phase counting and the ratio latch; a new ratio only takes effect on a
  // decimation edge so a frame is never split.
  always_comb begin
    accept   = bus.in_valid & ~bus.clr;
    dec_edge = accept && (phase_q == ratio_q - RC_W'(1));
    phase_d  = phase_q;
    ratio_d  = ratio_q;
    if (accept) begin
      phase_d = dec_edge ? '0 : phase_q + RC_W'(1);
    end
    if (dec_edge) begin
      ratio_d = RC_W'(clamp_ratio(int'(bus.dec_ratio), R_MAX));
    end
  end

  // Scale the comb result and clip it into the output range.
  always_comb begin
    shifted = g_comb[STAGES-1].c_out >>> bus.out_shift;
    sat_r   = saturate(SAT_W'(shifted), OUT_W);
  end

  assign unused_sat_bits = ^sat_r.val[SAT_W-1:OUT_W];

  // Control and output registers; clear has the same effect as reset and
  // drops any pending decimation strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      ratio_q     <= RC_W'(R_DEF);
      dec_stb_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      out_data_q  <= '0;
    end else if (bus.clr) begin
      phase_q     <= '0;
      ratio_q     <= RC_W'(R_DEF);
      dec_stb_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      ratio_q     <= ratio_d;
      dec_stb_q   <= dec_edge;
      out_valid_q <= dec_stb_q;
      out_sat_q   <= dec_stb_q & sat_r.sat;
      if (dec_stb_q) begin
        out_data_q <= sat_r.val[OUT_W-1:0];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: a 16-bit-output instance and an 8-bit
// (saturating) instance share one stimulus stream.
module tb_cic_decimator;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic signed [1:0] in_data;
  logic [4:0] dec_ratio;
  logic [4:0] out_shift;
  int         cyc;
  int         n_vec;
  int         n_err;

  int q16[$];
  int s16[$];
  int t16[$];
  int q8[$];
  int s8[$];

  // Hand-computed N=4, R=12 step response: 4th differences of C(n,4).
  int step_exp [8] = '{495, 8646, 19371, 20736, 20736, 20736, 20736, 20736};

  cic_if #(.STAGES(4), .IN_W(2), .R_MAX(16), .OUT_W(16)) bus16 ();
  cic_if #(.STAGES(4), .IN_W(2), .R_MAX(16), .OUT_W(8))  bus8 ();

  assign bus16.clr       = clr;
  assign bus16.in_valid  = in_valid;
  assign bus16.in_data   = in_data;
  assign bus16.dec_ratio = dec_ratio;
  assign bus16.out_shift = out_shift;
  assign bus8.clr        = clr;
  assign bus8.in_valid   = in_valid;
  assign bus8.in_data    = in_data;
  assign bus8.dec_ratio  = dec_ratio;
  assign bus8.out_shift  = out_shift;

  cic_decimator #(.STAGES(4), .IN_W(2), .R_MAX(16), .R_DEF(12), .OUT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  cic_decimator #(.STAGES(4), .IN_W(2), .R_MAX(16), .R_DEF(12), .OUT_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output strobe away from the active edge.
  always @(negedge clk) begin
    if (bus16.out_valid) begin
      q16.push_back(int'(bus16.out_data));
      s16.push_back(int'(bus16.out_sat));
      t16.push_back(cyc);
    end
    if (bus8.out_valid) begin
      q8.push_back(int'(bus8.out_data));
      s8.push_back(int'(bus8.out_sat));
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush();
    q16.delete(); s16.delete(); t16.delete(); q8.delete(); s8.delete();
  endtask

  task automatic do_clear();
    clr      = 1'b1;
    in_valid = 1'b0;
    cycles(2);
    clr      = 1'b0;
    flush();
  endtask

  // Run 100 cycles of +1 input at R=12 from clean state and compare with the
  // hand-computed step response, first-output latency and spacing.
  task automatic check_step(input string tag);
    int c0;
    in_data  = 2'sd1;
    in_valid = 1'b1;
    c0 = cyc;
    cycles(100);
    chk({tag, "_count"}, q16.size(), 8);
    if (q16.size() == 8) begin
      chk({tag, "_latency"}, t16[0] - c0, 13);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s_y%0d", tag, i), q16[i], step_exp[i]);
        chk($sformatf("%s_sat%0d", tag, i), s16[i], 0);
        if (i > 0) chk($sformatf("%s_gap%0d", tag, i), t16[i] - t16[i-1], 12);
      end
    end
  endtask

  initial begin
    int acc_n;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 2'sd0;
    dec_ratio = 5'd12;
    out_shift = 5'd0;

    // Reset state
    cycles(3);
    chk("rst_valid", bus16.out_valid, 0);
    chk("rst_data", bus16.out_data, 0);
    chk("rst_sat", bus16.out_sat, 0);
    chk("rst_data8", bus8.out_data, 0);
    rst_n = 1'b1;
    flush();

    // Step response, R=12, shift 0; 8-bit instance clips every strobe
    check_step("step");
    chk("sat8_count", q8.size(), 8);
    for (int i = 0; i < q8.size(); i++) begin
      chk($sformatf("sat8_y%0d", i), q8[i], 127);
      chk($sformatf("sat8_flag%0d", i), s8[i], 1);
    end

    // Negative input with scaling: -2*12^4 >>> 8 = -162
    do_clear();
    in_data   = -2'sd2;
    out_shift = 5'd8;
    in_valid  = 1'b1;
    cycles(100);
    chk("neg_count", q16.size(), 8);
    for (int i = 4; i < q16.size(); i++) begin
      chk($sformatf("neg_y%0d", i), q16[i], -162);
      chk($sformatf("neg_sat%0d", i), s16[i], 0);
    end
    for (int i = 4; i < q8.size(); i++) begin
      chk($sformatf("neg8_y%0d", i), q8[i], -128);
      chk($sformatf("neg8_sat%0d", i), s8[i], 1);
    end
    out_shift = 5'd0;

    // Ratio 12 -> 5 mid-frame: first frame still 12, then every 5, steady 625
    do_clear();
    begin
      int c0;
      in_data  = 2'sd1;
      in_valid = 1'b1;
      c0 = cyc;
      cycles(6);
      dec_ratio = 5'd5;
      cycles(43);
      chk("r5_count", q16.size(), 8);
      if (q16.size() == 8) begin
        chk("r5_first", t16[0] - c0, 13);
        for (int i = 1; i < 8; i++) chk($sformatf("r5_gap%0d", i), t16[i] - t16[i-1], 5);
        for (int i = 4; i < 8; i++) chk($sformatf("r5_y%0d", i), q16[i], 625);
      end
    end

    // dec_ratio 0 clamps to 2
    do_clear();
    dec_ratio = 5'd0;
    in_valid  = 1'b1;
    cycles(26);
    chk("r0_count", q16.size(), 7);
    for (int i = 1; i < q16.size(); i++) chk($sformatf("r0_gap%0d", i), t16[i] - t16[i-1], 2);

    // dec_ratio 31 clamps to 16
    do_clear();
    dec_ratio = 5'd31;
    in_valid  = 1'b1;
    cycles(62);
    chk("r31_count", q16.size(), 4);
    for (int i = 1; i < q16.size(); i++) chk($sformatf("r31_gap%0d", i), t16[i] - t16[i-1], 16);

    // Gapped input (~40% duty), long enough for the integrators to wrap
    do_clear();
    dec_ratio = 5'd12;
    in_data   = 2'sd1;
    acc_n     = 0;
    for (int i = 0; i < 30000; i++) begin
      in_valid = ($urandom_range(0, 9) < 4);
      if (in_valid) acc_n++;
      cycles(1);
    end
    in_valid = 1'b0;
    cycles(4);
    chk("gap_count", q16.size(), acc_n / 12);
    for (int i = 4; i < q16.size(); i++) begin
      chk($sformatf("gap_y%0d", i), q16[i], 20736);
    end

    // Reset asserted right after the decimation edge drops the pending strobe
    do_clear();
    in_data  = 2'sd1;
    in_valid = 1'b1;
    cycles(12);
    rst_n = 1'b0;
    cycles(1);
    chk("rstE_valid1", bus16.out_valid, 0);
    chk("rstE_data1", bus16.out_data, 0);
    cycles(1);
    chk("rstE_valid2", bus16.out_valid, 0);
    chk("rstE_sat2", bus16.out_sat, 0);
    chk("rstE_none", q16.size(), 0);
    rst_n = 1'b1;
    flush();
    check_step("after_rst");

    // Clear held with in_valid keeps everything at zero
    clr      = 1'b1;
    in_valid = 1'b1;
    cycles(20);
    chk("clr_valid", bus16.out_valid, 0);
    chk("clr_data", bus16.out_data, 0);
    clr = 1'b0;
    flush();
    check_step("after_clr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
